// File: rtl/core_control_fsm_pkg.sv
// Shared definitions for the core control sequencer: state codes and the
// position of the load/store L bit inside the decoder's ls_flags bus.
// The decoder and datapath import the same codes so debug views agree.
package core_control_fsm_pkg;

  // Sequencer states; codes 6 and 7 are unused and recover to FETCH.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5
  } state_t;

  // ls_flags is {P,U,B,W,L}; L selects load (1) versus store (0).
  localparam int LS_L_BIT = 0;

  // True for the two states that sit waiting on a memory acknowledge.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/core_control_fsm_wait_timer.sv
// Wait-cycle timer for the core control sequencer. Counts consecutive
// cycles spent waiting on a memory acknowledge and flags expiry on the
// TIMEOUT_CYCLES-th waiting cycle. Only instantiated when the top is built
// with CORE_CTRL_MEM_TIMEOUT_EN defined.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] count;

  // Expiry is reported combinationally during the waiting cycle itself, so
  // the sequencer can abort in that same cycle (an ack in that cycle wins,
  // because the top only enables the timer when no ack is present).
  assign expired = enable && (count == TW'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever the wait ends, the state changes or it expires;
  // it never passes TIMEOUT_CYCLES-1 because expiry also clears it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle core sequencer: FETCH -> DECODE -> EXEC / MEM (-> WB) / BRANCH.
// Drives IR load, PC update, the data-memory handshake and register-file /
// flag write enables from the decoder's outputs, and counts retired
// instructions (skipped instructions are not counted).
//
// Optional feature: define CORE_CTRL_MEM_TIMEOUT_EN to bound the wait for
// imem_ack / dmem_ack to TIMEOUT_CYCLES cycles. On expiry abort pulses; a
// fetch is retried, a data access is abandoned without retiring. Without
// the macro the sequencer waits indefinitely and abort is tied low.
module core_control_fsm
  import core_control_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ig_ex,
  input  logic             br_en,
  input  logic             link,
  input  logic             mem_op,
  input  logic [4:0]       ls_flags,
  input  logic             write_rd,
  input  logic             update_flags,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             flags_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             abort
);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic             load_op;
  logic             expired;

  assign load_op = ls_flags[LS_L_BIT];

`ifdef CORE_CTRL_MEM_TIMEOUT_EN
  logic waiting;
  logic timer_clear;

  // A cycle counts as waiting only while in FETCH/MEM without the matching
  // ack; any other cycle (including the ack cycle itself) restarts the timer,
  // which is what clears it on every state entry.
  assign waiting     = !rst && is_wait_state(state_q) &&
                       ((state_q == ST_FETCH) ? !imem_ack : !dmem_ack);
  assign timer_clear = !waiting || expired;

  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (waiting),
    .expired(expired)
  );
`else
  logic [31:0] unused_timeout_cfg;

  assign expired            = 1'b0;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  logic unused_ls_flags;
  assign unused_ls_flags = ^ls_flags[4:1];

  // Sequencer state and retired-instruction counter. Decoder inputs are only
  // looked at from DECODE onwards; acks only in their own wait state, so a
  // stray ack elsewhere has no effect. Retirement happens on the cycle an
  // instruction leaves its final state; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ig_ex) begin
            state_q <= ST_FETCH;
          end else if (br_en) begin
            state_q <= ST_BRANCH;
          end else if (mem_op) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          count_q <= count_q + 1'b1;
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (load_op) begin
              state_q <= ST_WB;
            end else begin
              state_q <= ST_FETCH;
              count_q <= count_q + 1'b1;
            end
          end else if (expired) begin
            state_q <= ST_FETCH;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          count_q <= count_q + 1'b1;
        end
        ST_BRANCH: begin
          state_q <= ST_FETCH;
          count_q <= count_q + 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Control outputs decoded from the registered state plus current inputs so
  // ir_load/pc_inc can fire in the same cycle as imem_ack. Reset forces every
  // output low immediately, dropping any pending request. On a timeout the
  // request stays up through the expiry cycle (a late ack there is still
  // honoured) and drops on the following cycle.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
          pc_inc   = imem_ack;
        end
        ST_EXEC: begin
          rf_we    = write_rd;
          flags_we = update_flags;
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = !load_op;
        end
        ST_WB: begin
          rf_we = 1'b1;
        end
        ST_BRANCH: begin
          pc_load = 1'b1;
          rf_we   = link;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign state       = rst ? 3'd0 : state_q;
  assign instr_count = rst ? '0 : count_q;
  assign abort       = expired;

endmodule

// File: tb/tb_core_control_fsm.sv
// Self-checking bench for core_control_fsm. Instructions are described at
// the instruction level (kind, fetch latency, data latency); a reference
// model predicts per-instruction totals (cycles, pulses, retirement) and the
// bench compares them with what the DUT produced, plus directed state traces.
module tb_core_control_fsm;

  localparam int CW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ig_ex = 1'b0, br_en = 1'b0, link = 1'b0, mem_op = 1'b0;
  logic [4:0]    ls_flags = 5'd0;
  logic          write_rd = 1'b0, update_flags = 1'b0;
  logic          imem_ack = 1'b0, dmem_ack = 1'b0;
  logic          imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we;
  logic          rf_we, flags_we, abort;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_count = '0;

  int obs_imem_req, obs_ir_load, obs_pc_inc, obs_pc_load, obs_dmem_req;
  int obs_dmem_we, obs_rf_we, obs_flags_we, obs_abort;
  int trace[$];
  logic [2:0]    fin_state;
  logic [CW-1:0] fin_count;

  typedef struct {
    int cycles, imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, rf_we, flags_we, retire;
  } expect_t;

  core_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ig_ex(ig_ex), .br_en(br_en), .link(link),
    .mem_op(mem_op), .ls_flags(ls_flags), .write_rd(write_rd),
    .update_flags(update_flags), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .flags_we(flags_we),
    .state(state), .instr_count(instr_count), .abort(abort)
  );

  always #5 clk = ~clk;

  // Reference model: what one instruction should do, from its kind and the
  // number of no-ack cycles before each memory acknowledge.
  function automatic expect_t predict(input bit ig, br, lnk, memop, l, wrd, upd,
                                      input int fd, md);
    expect_t e;
    e = '{cycles: fd + 2, imem_req: fd + 1, ir_load: 1, pc_inc: 1, pc_load: 0,
          dmem_req: 0, dmem_we: 0, rf_we: 0, flags_we: 0, retire: 0};
    if (ig) begin
      e.retire = 0;
    end else if (br) begin
      e.cycles += 1; e.pc_load = 1; e.rf_we = int'(lnk); e.retire = 1;
    end else if (memop) begin
      e.cycles  += md + 1 + int'(l);
      e.dmem_req = md + 1;
      e.dmem_we  = l ? 0 : md + 1;
      e.rf_we    = int'(l);
      e.retire   = 1;
    end else begin
      e.cycles += 1; e.rf_we = int'(wrd); e.flags_we = int'(upd); e.retire = 1;
    end
    return e;
  endfunction

  function automatic string trace_str();
    string s = "";
    foreach (trace[i]) s = {s, $sformatf("%0d", trace[i])};
    return s;
  endfunction

  // Runs one instruction for ncyc cycles acting as both memories; stray acks
  // are thrown in whenever no request is up. Leaves one idle FETCH cycle.
  task automatic run_instr(input bit ig, br, lnk, memop, input logic [4:0] lsf,
                           input bit wrd, upd, input int fd, md, ncyc);
    int iseen = 0;
    int dseen = 0;
    ig_ex = ig; br_en = br; link = lnk; mem_op = memop; ls_flags = lsf;
    write_rd = wrd; update_flags = upd;
    obs_imem_req = 0; obs_ir_load = 0; obs_pc_inc = 0; obs_pc_load = 0;
    obs_dmem_req = 0; obs_dmem_we = 0; obs_rf_we = 0; obs_flags_we = 0; obs_abort = 0;
    trace.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      if (imem_req) begin imem_ack = (iseen == fd); iseen++; end
      else imem_ack = 1'($urandom_range(0, 1));
      if (dmem_req) begin dmem_ack = (dseen == md); dseen++; end
      else dmem_ack = 1'($urandom_range(0, 1));
      #1;
      trace.push_back(int'(state));
      obs_imem_req += int'(imem_req); obs_ir_load += int'(ir_load);
      obs_pc_inc   += int'(pc_inc);   obs_pc_load += int'(pc_load);
      obs_dmem_req += int'(dmem_req); obs_dmem_we += int'(dmem_we);
      obs_rf_we    += int'(rf_we);    obs_flags_we += int'(flags_we);
      obs_abort    += int'(abort);
    end
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    fin_state = state;
    fin_count = instr_count;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, rf_we, flags_we, abort} !== 9'd0) begin
      n_bad++; $display("[TB] FAIL reset_outputs: got %b required 0", {imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we, rf_we, flags_we, abort});
    end
    n_cmp++;
    if (state !== 3'd0 || instr_count !== '0) begin
      n_bad++; $display("[TB] FAIL reset_state: got state %0d count %0d required 0/0", state, instr_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || imem_req !== 1'b1) begin
      n_bad++; $display("[TB] FAIL reset_release: got state %0d imem_req %b required 0/1", state, imem_req);
    end
  endtask

  task automatic test_alu();
    expect_t e = predict(0, 0, 0, 0, 0, 1, 1, 1, 0);
    run_instr(0, 0, 0, 0, 5'd0, 1, 1, 1, 0, e.cycles);
    exp_count = exp_count + CW'(e.retire);
    n_cmp++;
    if (trace_str() != "0012" || fin_state !== 3'd0) begin
      n_bad++; $display("[TB] FAIL alu_trace: got %s then %0d required 0012 then 0", trace_str(), fin_state);
    end
    n_cmp++;
    if (obs_rf_we != 1 || obs_flags_we != 1 || obs_ir_load != 1 || obs_pc_inc != 1) begin
      n_bad++; $display("[TB] FAIL alu_enables: got rf_we %0d flags_we %0d ir_load %0d pc_inc %0d required 1 each", obs_rf_we, obs_flags_we, obs_ir_load, obs_pc_inc);
    end
    n_cmp++;
    if (fin_count !== 8'd1) begin
      n_bad++; $display("[TB] FAIL alu_count: got %0d required 1", fin_count);
    end
  endtask

  task automatic test_skip();
    expect_t e = predict(1, 1, 1, 1, 1, 1, 1, 0, 0);
    run_instr(1, 1, 1, 1, 5'd1, 1, 1, 0, 0, e.cycles);
    n_cmp++;
    if (trace_str() != "01" || fin_state !== 3'd0) begin
      n_bad++; $display("[TB] FAIL skip_trace: got %s then %0d required 01 then 0", trace_str(), fin_state);
    end
    n_cmp++;
    if (obs_rf_we != 0 || obs_flags_we != 0 || obs_pc_load != 0 || obs_dmem_req != 0) begin
      n_bad++; $display("[TB] FAIL skip_enables: got rf_we %0d flags_we %0d pc_load %0d dmem_req %0d required 0", obs_rf_we, obs_flags_we, obs_pc_load, obs_dmem_req);
    end
    n_cmp++;
    if (fin_count !== exp_count) begin
      n_bad++; $display("[TB] FAIL skip_count: got %0d required %0d", fin_count, exp_count);
    end
  endtask

  task automatic test_load_store_bl();
    expect_t e;
    e = predict(0, 0, 0, 1, 1, 0, 0, 0, 2);
    run_instr(0, 0, 0, 1, 5'b11001, 0, 0, 0, 2, e.cycles);
    exp_count = exp_count + CW'(e.retire);
    n_cmp++;
    if (trace_str() != "013334" || obs_dmem_req != 3 || obs_dmem_we != 0 || obs_rf_we != 1) begin
      n_bad++; $display("[TB] FAIL load: got trace %s dmem_req %0d dmem_we %0d rf_we %0d required 013334/3/0/1", trace_str(), obs_dmem_req, obs_dmem_we, obs_rf_we);
    end
    n_cmp++;
    if (fin_count !== exp_count) begin
      n_bad++; $display("[TB] FAIL load_count: got %0d required %0d", fin_count, exp_count);
    end
    e = predict(0, 0, 0, 1, 0, 1, 1, 0, 1);
    run_instr(0, 0, 0, 1, 5'b11000, 1, 1, 0, 1, e.cycles);
    exp_count = exp_count + CW'(e.retire);
    n_cmp++;
    if (trace_str() != "0133" || fin_state !== 3'd0 || obs_dmem_we != 2 || obs_rf_we != 0 || obs_flags_we != 0) begin
      n_bad++; $display("[TB] FAIL store: got trace %s state %0d dmem_we %0d rf_we %0d flags_we %0d required 0133/0/2/0/0", trace_str(), fin_state, obs_dmem_we, obs_rf_we, obs_flags_we);
    end
    e = predict(0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 1, 0, 5'd0, 0, 0, 0, 0, e.cycles);
    exp_count = exp_count + CW'(e.retire);
    n_cmp++;
    if (trace_str() != "015" || obs_pc_load != 1 || obs_rf_we != 1) begin
      n_bad++; $display("[TB] FAIL branch_link: got trace %s pc_load %0d rf_we %0d required 015/1/1", trace_str(), obs_pc_load, obs_rf_we);
    end
    n_cmp++;
    if (fin_count !== exp_count) begin
      n_bad++; $display("[TB] FAIL branch_count: got %0d required %0d", fin_count, exp_count);
    end
  endtask

  // Random mix long enough for the 8-bit retire counter to wrap.
  task automatic test_random();
    int ob[12];
    int ex[12];
    string nm[12] = '{"cycles_to_fetch", "imem_req", "ir_load", "pc_inc", "pc_load", "dmem_req",
                      "dmem_we", "rf_we", "flags_we", "abort", "final_state", "instr_count"};
    for (int it = 0; it < 400; it++) begin
      bit ig, br, lnk, memop, wrd, upd;
      logic [4:0] lsf;
      int fd, md;
      expect_t e;
      ig = ($urandom_range(0, 4) == 0); br = 1'($urandom_range(0, 1)); lnk = 1'($urandom_range(0, 1));
      memop = 1'($urandom_range(0, 1)); wrd = 1'($urandom_range(0, 1)); upd = 1'($urandom_range(0, 1));
      lsf = 5'($urandom_range(0, 31));
      fd = $urandom_range(0, 2); md = $urandom_range(0, 2);
      e = predict(ig, br, lnk, memop, lsf[0], wrd, upd, fd, md);
      run_instr(ig, br, lnk, memop, lsf, wrd, upd, fd, md, e.cycles);
      exp_count = exp_count + CW'(e.retire);
      ob = '{trace.size(), obs_imem_req, obs_ir_load, obs_pc_inc, obs_pc_load, obs_dmem_req,
             obs_dmem_we, obs_rf_we, obs_flags_we, obs_abort, int'(fin_state), int'(fin_count)};
      ex = '{e.cycles, e.imem_req, e.ir_load, e.pc_inc, e.pc_load, e.dmem_req,
             e.dmem_we, e.rf_we, e.flags_we, 0, 0, int'(exp_count)};
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (ob[k] != ex[k]) begin
          n_bad++; $display("[TB] FAIL random_%s (iter %0d): got %0d required %0d", nm[k], it, ob[k], ex[k]);
        end
      end
    end
  endtask

  task automatic test_reset_in_mem();
    int guard = 0;
    ig_ex = 0; br_en = 0; mem_op = 1; ls_flags = 5'b00001;
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    while (dmem_req !== 1'b1 && guard < 10) begin
      @(negedge clk); #1; guard++;
    end
    n_cmp++;
    if (dmem_req !== 1'b1 || state !== 3'd3) begin
      n_bad++; $display("[TB] FAIL reach_mem: got dmem_req %b state %0d required 1/3", dmem_req, state);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rst_drops_req: got %b required 0", dmem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_count = '0;
    n_cmp++;
    if (state !== 3'd0 || dmem_req !== 1'b0 || instr_count !== '0 || imem_req !== 1'b1) begin
      n_bad++; $display("[TB] FAIL rst_in_mem: got state %0d dmem_req %b count %0d imem_req %b required 0/0/0/1", state, dmem_req, instr_count, imem_req);
    end
  endtask

  task automatic test_timeout();
`ifdef CORE_CTRL_MEM_TIMEOUT_EN
    ig_ex = 0; br_en = 0; mem_op = 1; ls_flags = 5'b00001;
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (abort !== (i == TO) || dmem_req !== 1'b1) begin
        n_bad++; $display("[TB] FAIL mem_timeout wait %0d: got abort %b dmem_req %b required %b/1", i, abort, dmem_req, i == TO);
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if (state !== 3'd0 || abort !== 1'b0 || dmem_req !== 1'b0 || instr_count !== exp_count) begin
      n_bad++; $display("[TB] FAIL mem_timeout_exit: got state %0d abort %b dmem_req %b count %0d required 0/0/0/%0d", state, abort, dmem_req, instr_count, exp_count);
    end
    imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); dmem_ack = (i == TO); #1;
      n_cmp++;
      if (abort !== 1'b0) begin
        n_bad++; $display("[TB] FAIL ack_on_expiry wait %0d: got abort %b required 0", i, abort);
      end
    end
    @(negedge clk); dmem_ack = 1'b0; #1;
    n_cmp++;
    if (state !== 3'd4 || rf_we !== 1'b1) begin
      n_bad++; $display("[TB] FAIL ack_on_expiry_wb: got state %0d rf_we %b required 4/1", state, rf_we);
    end
    exp_count = exp_count + 1'b1;
    @(negedge clk); #1;
    for (int i = 1; i <= TO; i++) begin
      if (i > 1) begin @(negedge clk); #1; end
      n_cmp++;
      if (abort !== (i == TO) || imem_req !== 1'b1 || state !== 3'd0) begin
        n_bad++; $display("[TB] FAIL fetch_timeout wait %0d: got abort %b imem_req %b state %0d required %b/1/0", i, abort, imem_req, state, i == TO);
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if (state !== 3'd0 || abort !== 1'b0 || instr_count !== exp_count) begin
      n_bad++; $display("[TB] FAIL fetch_retry: got state %0d abort %b count %0d required 0/0/%0d", state, abort, instr_count, exp_count);
    end
`else
    @(negedge clk); #1;
    n_cmp++;
    if (abort !== 1'b0) begin
      n_bad++; $display("[TB] FAIL abort_tied: got %b required 0", abort);
    end
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting core_control_fsm bench");
    test_reset();
    test_alu();
    test_skip();
    test_load_store_bl();
    test_random();
    test_reset_in_mem();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
